rr_arb_n: RTL and testbench
===========================

// Module: rr_arb_n
// PURPOSE
//  Parametrised N-channel round-robin arbiter for the switch fabric; replaces the fixed 4-port arbiter.
//  Grants one requester at a time and holds the grant until that requester releases its req.
//  The pointer advances past the actual winner, not by +1, so arbitration is truly fair.
//  Adds per-channel mask, optional max-hold preemption, and zero-bubble handoff between owners.
// PARAMETERS
//  N         4   number of request channels, N >= 2
//  MAX_HOLD  0   max grant length in cycles; 0 = unlimited (no preemption)
//  IDW       $clog2(N)   width of the channel index (derived; do not override)
// PORTS
//  clk        in   1    single clock, all state updates on posedge
//  rst        in   1    asynchronous reset, active-low (asserted when 0)
//  req        in   N    per-channel request, level, held until transfer done
//  mask       in   N    1 = channel may not win a new arbitration
//  gnt        out  N    one-hot grant (all-zero when idle), registered
//  gnt_vld    out  1    |gnt, registered
//  gnt_id     out  IDW  index of granted channel; 0 when idle
// BEHAVIOUR
//  Reset (rst==0, async): gnt=0, gnt_vld=0, gnt_id=0, ptr=0, hold_cnt=0, state=IDLE.
//  Eligible vector: elig = req & ~mask. Winner = first set bit of elig scanning ptr, ptr+1, ... mod N.
//  Latency: req seen at edge k -> gnt driven after edge k (1 cycle). All outputs come from flops.
//  FSM IDLE: if elig!=0, at the edge: gnt<=onehot(winner), state<=BUSY, hold_cnt<=0. Else stay.
//  FSM BUSY, owner o:
//   - req[o]==1 and no preemption: keep gnt; hold_cnt<=hold_cnt+1, saturating at MAX_HOLD-1.
//   - req[o]==0 (release): ptr<=o+1 mod N. Rearbitrate elig with that ptr in the same edge.
//     If there is a winner, grant it directly (no idle bubble), hold_cnt<=0.
//     If there is none: gnt<=0, state<=IDLE.
//   - Preempt (MAX_HOLD>0, hold_cnt==MAX_HOLD-1, elig & ~onehot(o) != 0):
//     ptr<=o+1; grant the winner among the others; hold_cnt<=0.
//     o keeps req high and requeues at the lowest priority.
//   - Preempt condition with no other eligible requester: keep o, hold_cnt<=0.
//  Mask applies only to new arbitration. Masking the current owner does not revoke its grant.
//  Wrap-around: ptr and scans are mod N. ptr==N-1 scans N-1,0,1,...
//  Simultaneous release + new req on the same edge: the new req competes in that same arbitration.
//  Reset mid-grant: outputs drop asynchronously. After reset is released, arbitration restarts from ptr=0.
//  Invariants: $onehot0(gnt) always; gnt_vld==|gnt; gnt_id==index(gnt).
//  A channel holding req continuously with others contending is granted within N-1 grants.
// STRUCTURE
//  sw_pkg: ASSERT/NEGATE constants (replacing the sw.vh macros), arb_state_t enum {IDLE,BUSY}.
//  sw_pkg also holds the function onehot2idx #(N).
//  Sub-module rr_pick #(N): combinational rotating-priority picker.
//  rr_pick inputs: vec[N], ptr[IDW]. Outputs: found, idx[IDW], onehot[N].
//  rr_pick implemented as a double-width masked priority encode; no loops with variable bounds.
//  The top level holds the FSM, ptr, hold_cnt ($clog2(MAX_HOLD+1) bits, absent when MAX_HOLD==0), and output flops.
// TESTING (N=4 unless stated)
//  1 Reset: rst=0 with req=4'b1111 -> gnt=0, gnt_vld=0. Release rst -> next edge gnt=4'b0001, gnt_id=0.
//  2 Fairness: req=4'b1111 held, each owner drops req for 1 cycle after 3 cycles, then re-asserts.
//    Required grant order: 0,1,2,3,0 with no idle cycle between grants.
//  3 Skip pointer: ptr=0, only req[2] -> gnt=4'b0100. Release -> ptr=3.
//    Then req=4'b0101 -> gnt=4'b0001 (not channel 2).
//  4 Mask: req=4'b0011, mask=4'b0001 -> gnt=4'b0010.
//    Set mask=4'b0010 while ch1 is granted -> gnt stays 4'b0010 until req[1] drops.
//  5 Preempt: MAX_HOLD=4, req=4'b0011 held -> ch0 granted 4 cycles, then ch1 4 cycles, alternating.
//    With req=4'b0001 only -> ch0 is held indefinitely.
//  6 Wrap: N=5, ptr=4, req=5'b00011 -> gnt=5'b00001.
//    Random req/mask with assertions (onehot0, starvation bound) for 10k cycles.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared switch-fabric definitions: level constants, arbiter state encoding, index helper.
package sw_pkg;

  localparam logic Assert = 1'b1;
  localparam logic Negate = 1'b0;

  // Widest channel vector onehot2idx can decode.
  localparam int unsigned MaxN = 64;

  typedef enum logic {
    StIdle,
    StBusy
  } arb_state_t;

  // Index of the set bit in a one-hot vector; 0 for an all-zero vector.
  function automatic int unsigned onehot2idx(input logic [MaxN-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb_n_pick.sv
// Rotating-priority picker: lowest set bit of vec at or after ptr, wrapping mod N.
module rr_pick
  import sw_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   vec,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx,
  output logic [N-1:0]   onehot
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  // Duplicate vec, drop bits below ptr in the low copy, isolate the lowest survivor, fold halves.
  always_comb begin
    dbl    = {vec, vec};
    masked = dbl & ({(2*N){1'b1}} << ptr);
    first  = masked & ((~masked) + {{(2*N-1){1'b0}}, 1'b1});
    onehot = first[N-1:0] | first[2*N-1:N];
    found  = |vec;
    idx    = IDW'(onehot2idx(MaxN'(onehot)));
  end

endmodule

// File: rtl/rr_arb_n.sv
// N-channel round-robin arbiter with per-channel mask, optional max-hold preemption and
// zero-bubble handoff between owners. All outputs are registered.
module rr_arb_n
  import sw_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 0,
  parameter int unsigned IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  output logic [N-1:0]   gnt,
  output logic           gnt_vld,
  output logic [IDW-1:0] gnt_id
);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           gnt_vld_q, gnt_vld_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;

  logic [N-1:0]   elig;
  logic [N-1:0]   pick_vec;
  logic [IDW-1:0] pick_ptr;
  logic [IDW-1:0] owner_next;
  logic           owner_req;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [N-1:0]   pick_onehot;
  logic           hold_clr;
  logic           hold_inc;
  logic           hold_at_max;

  // Picker inputs: the owner is never a candidate, and while busy the scan starts past it.
  always_comb begin
    elig       = req & ~mask;
    pick_vec   = elig & ~gnt_q;
    owner_req  = |(req & gnt_q);
    owner_next = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);
    pick_ptr   = (state_q == StBusy) ? owner_next : ptr_q;
  end

  rr_pick #(
    .N  (N),
    .IDW(IDW)
  ) u_pick (
    .vec   (pick_vec),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx),
    .onehot(pick_onehot)
  );

  // Arbitration FSM: grant, hold, release with same-edge handoff, preempt on hold expiry.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    hold_clr = 1'b0;
    hold_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          gnt_d    = pick_onehot;
          gnt_id_d = pick_idx;
          state_d  = StBusy;
          hold_clr = 1'b1;
        end
      end
      StBusy: begin
        if (!owner_req) begin
          ptr_d    = owner_next;
          hold_clr = 1'b1;
          if (pick_found) begin
            gnt_d    = pick_onehot;
            gnt_id_d = pick_idx;
          end else begin
            gnt_d    = '0;
            gnt_id_d = '0;
            state_d  = StIdle;
          end
        end else if (hold_at_max) begin
          // Owner keeps req but has used its slot; it requeues behind everyone else.
          hold_clr = 1'b1;
          if (pick_found) begin
            ptr_d    = owner_next;
            gnt_d    = pick_onehot;
            gnt_id_d = pick_idx;
          end
        end else begin
          hold_inc = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    gnt_vld_d = |gnt_d;
  end

  if (MAX_HOLD > 0) begin : g_hold
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    assign hold_at_max = (hold_cnt_q == HW'(MAX_HOLD - 1));

    // Cycles the current owner has held the grant, saturating at MAX_HOLD-1.
    always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (hold_clr) begin
        hold_cnt_d = '0;
      end else if (hold_inc && !hold_at_max) begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold_cnt_q <= '0;
      end else begin
        hold_cnt_q <= hold_cnt_d;
      end
    end
  end else begin : g_no_hold
    logic unused_hold;
    assign unused_hold = hold_clr ^ hold_inc;
    assign hold_at_max = 1'b0;
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_vld_q <= Negate;
      gnt_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_id_q  <= gnt_id_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign gnt_id  = gnt_id_q;

endmodule

// File: tb/tb_rr_arb_n.sv
// Bench for rr_arb_n: three configurations (N=4 unlimited, N=4 MAX_HOLD=4, N=5) against
// a behavioural round-robin model, plus literal checks of the directed scenarios.
module tb_rr_arb_n;

  logic clk;
  logic rst;

  logic [7:0] in_req[3];
  logic [7:0] in_mask[3];

  logic [3:0] req0, mask0, gnt0;
  logic [3:0] req1, mask1, gnt1;
  logic [4:0] req2, mask2, gnt2;
  logic       vld0, vld1, vld2;
  logic [1:0] id0, id1;
  logic [2:0] id2;

  logic [7:0] a_gnt[3];
  logic [7:0] a_id[3];
  logic       a_vld[3];

  int checks;
  int errors;

  // Model state: owner (-1 when idle), scan pointer, cycles the owner has held the grant.
  int m_owner[3];
  int m_ptr[3];
  int m_held[3];
  int n_of[3];
  int mh_of[3];

  assign req0  = in_req[0][3:0];
  assign mask0 = in_mask[0][3:0];
  assign req1  = in_req[1][3:0];
  assign mask1 = in_mask[1][3:0];
  assign req2  = in_req[2][4:0];
  assign mask2 = in_mask[2][4:0];

  assign a_gnt[0] = {4'b0, gnt0};
  assign a_gnt[1] = {4'b0, gnt1};
  assign a_gnt[2] = {3'b0, gnt2};
  assign a_id[0]  = {6'b0, id0};
  assign a_id[1]  = {6'b0, id1};
  assign a_id[2]  = {5'b0, id2};
  assign a_vld[0] = vld0;
  assign a_vld[1] = vld1;
  assign a_vld[2] = vld2;

  rr_arb_n #(.N(4), .MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .mask(mask0),
    .gnt(gnt0), .gnt_vld(vld0), .gnt_id(id0)
  );

  rr_arb_n #(.N(4), .MAX_HOLD(4)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .mask(mask1),
    .gnt(gnt1), .gnt_vld(vld1), .gnt_id(id1)
  );

  rr_arb_n #(.N(5), .MAX_HOLD(0)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .mask(mask2),
    .gnt(gnt2), .gnt_vld(vld2), .gnt_id(id2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input int n, input int p, input logic [7:0] v);
    for (int k = 0; k < n; k++) begin
      int c;
      c = (p + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input int i);
    logic [7:0] elig;
    logic [7:0] others;
    int w;
    int nxt;
    if (!rst) begin
      m_owner[i] = -1;
      m_ptr[i]   = 0;
      m_held[i]  = 0;
      return;
    end
    elig = in_req[i] & ~in_mask[i];
    if (m_owner[i] < 0) begin
      w = pick(n_of[i], m_ptr[i], elig);
      if (w >= 0) begin
        m_owner[i] = w;
        m_held[i]  = 1;
      end
    end else begin
      nxt = (m_owner[i] + 1) % n_of[i];
      if (!in_req[i][m_owner[i]]) begin
        m_ptr[i]   = nxt;
        m_owner[i] = pick(n_of[i], nxt, elig);
        m_held[i]  = 1;
      end else if (mh_of[i] > 0 && m_held[i] >= mh_of[i]) begin
        others = elig;
        others[m_owner[i]] = 1'b0;
        w = pick(n_of[i], nxt, others);
        if (w >= 0) begin
          m_ptr[i]   = nxt;
          m_owner[i] = w;
        end
        m_held[i] = 1;
      end else begin
        m_held[i]++;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e_gnt;
      logic [7:0] e_id;
      logic       e_vld;
      e_gnt = (m_owner[i] >= 0) ? (8'd1 << m_owner[i]) : 8'd0;
      e_id  = (m_owner[i] >= 0) ? 8'(m_owner[i]) : 8'd0;
      e_vld = (m_owner[i] >= 0);
      checks++;
      if (a_gnt[i] !== e_gnt || a_id[i] !== e_id || a_vld[i] !== e_vld) begin
        errors++;
        $display("FAIL model dut%0d t=%0t: got gnt=%b vld=%b id=%0d, expected gnt=%b vld=%b id=%0d",
                 i, $time, a_gnt[i], a_vld[i], a_id[i], e_gnt, e_vld, e_id);
      end
    end
  endtask

  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock: model advances on the edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    n_of[0]  = 4; n_of[1]  = 4; n_of[2]  = 5;
    mh_of[0] = 0; mh_of[1] = 4; mh_of[2] = 0;
    for (int i = 0; i < 3; i++) begin
      m_owner[i] = -1;
      m_ptr[i]   = 0;
      m_held[i]  = 0;
      in_req[i]  = 8'h00;
      in_mask[i] = 8'h00;
    end

    // Reset with all requests up.
    rst       = 1'b0;
    in_req[0] = 8'h0F;
    #1;
    lit("reset_gnt", a_gnt[0], 8'h00);
    lit("reset_vld", {7'b0, a_vld[0]}, 8'h00);
    tick();
    tick();
    rst = 1'b1;
    tick();
    lit("first_gnt", a_gnt[0], 8'h01);
    lit("first_id", a_id[0], 8'h00);

    // Fairness: each owner holds 3 cycles, drops req for one cycle.
    for (int g = 1; g <= 4; g++) begin
      tick();
      tick();
      in_req[0][(g - 1) % 4] = 1'b0;
      tick();
      in_req[0] = 8'h0F;
      lit($sformatf("fair_id%0d", g), a_id[0], 8'(g % 4));
      lit($sformatf("fair_vld%0d", g), {7'b0, a_vld[0]}, 8'h01);
    end

    // Reset mid-grant drops outputs without a clock, and restarts the pointer at 0.
    rst       = 1'b0;
    in_req[0] = 8'h00;
    #1;
    lit("async_gnt", a_gnt[0], 8'h00);
    lit("async_vld", {7'b0, a_vld[0]}, 8'h00);
    tick();
    rst       = 1'b1;
    in_req[0] = 8'h04;
    tick();
    lit("skip_gnt2", a_gnt[0], 8'h04);
    in_req[0] = 8'h00;
    tick();
    lit("skip_idle", a_gnt[0], 8'h00);
    in_req[0] = 8'h05;
    tick();
    lit("skip_ptr3", a_gnt[0], 8'h01);
    in_req[0] = 8'h00;
    tick();

    // Mask blocks new wins only.
    in_req[0]  = 8'h03;
    in_mask[0] = 8'h01;
    tick();
    lit("mask_gnt1", a_gnt[0], 8'h02);
    in_mask[0] = 8'h02;
    for (int k = 0; k < 3; k++) begin
      tick();
      lit($sformatf("mask_keep%0d", k), a_gnt[0], 8'h02);
    end
    in_req[0] = 8'h01;
    tick();
    lit("mask_handoff", a_gnt[0], 8'h01);
    in_req[0]  = 8'h00;
    in_mask[0] = 8'h00;
    tick();

    // Preemption with MAX_HOLD=4.
    in_req[1] = 8'h03;
    for (int t = 0; t < 16; t++) begin
      tick();
      lit($sformatf("preempt_id_t%0d", t), a_id[1], 8'((t / 4) % 2));
    end
    in_req[1] = 8'h01;
    for (int t = 0; t < 10; t++) begin
      tick();
      lit($sformatf("solo_gnt_t%0d", t), a_gnt[1], 8'h01);
    end
    in_req[1] = 8'h00;
    tick();

    // Wrap with N=5: get ptr to 4, then ptr 4 scans 4,0,1...
    in_req[2] = 8'h08;
    tick();
    lit("wrap_gnt3", a_gnt[2], 8'h08);
    in_req[2] = 8'h00;
    tick();
    in_req[2] = 8'h03;
    tick();
    lit("wrap_gnt0", a_gnt[2], 8'h01);
    in_req[2] = 8'h00;
    tick();

    // Random traffic on all three instances, with one reset pulse.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc == 5000) rst = 1'b0;
      if (cyc == 5001) rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
        for (int b = 0; b < n_of[i]; b++) begin
          if ($urandom_range(5) == 0) in_req[i][b] = ~in_req[i][b];
        end
        if ($urandom_range(7) == 0) in_mask[i] = 8'($urandom_range(255)) & 8'($urandom_range(255));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
